// File: rtl/result_drain_if.sv
// Valid/ready stream carrying requantized result elements toward the next layer.
interface result_drain_if #(
  parameter int OUT_WIDTH = 6
);
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/result_drain.sv
// Snapshots the multiplier result matrix after a fixed latency, requantizes each
// element (arithmetic shift + saturate) and streams it out in row-major order.
module result_drain #(
  parameter int WIDTH     = 6,
  parameter int N         = 3,
  parameter int OUT_WIDTH = 6,
  parameter int SHIFT     = 2,
  parameter int LATENCY   = 3 * N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [2*WIDTH-1:0] resultMatrix [N][N],
  output logic                      busy,
  output logic                      done,
  result_drain_if.master            out_if
);

  localparam int DW    = 2 * WIDTH;
  localparam int NN    = N * N;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int MAX_I = (1 << (OUT_WIDTH - 1)) - 1;
  localparam int MIN_I = -(1 << (OUT_WIDTH - 1));
  localparam logic signed [DW-1:0]    MAX_V    = DW'(MAX_I);
  localparam logic signed [DW-1:0]    MIN_V    = DW'(MIN_I);
  localparam logic        [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STREAM = 2'd2} state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic signed [DW-1:0]    snap_r [NN];
  logic signed [DW-1:0]    live_s [NN];
  logic                    done_r;
  logic                    load_s;
  logic                    capture_s;
  logic                    advance_s;
  logic                    finish_s;

  // Shift with floor rounding, then clamp into the output range.
  function automatic logic signed [OUT_WIDTH-1:0] requant(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] shifted;
    shifted = x >>> SHIFT;
    if (shifted > MAX_V) begin
      requant = MAX_V[OUT_WIDTH-1:0];
    end else if (shifted < MIN_V) begin
      requant = MIN_V[OUT_WIDTH-1:0];
    end else begin
      requant = shifted[OUT_WIDTH-1:0];
    end
  endfunction

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign live_s[r*N+c] = resultMatrix[r][c];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    capture_s = 1'b0;
    advance_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_W'(1)) begin
          capture_s = 1'b1;
          state_s   = STREAM;
        end else begin
          state_s = WAIT;
        end
      end
      STREAM: begin
        if (out_if.out_ready) begin
          if (idx_r == LAST_IDX) begin
            finish_s = 1'b1;
            state_s  = IDLE;
          end else begin
            advance_s = 1'b1;
            state_s   = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Latency counter, element index, snapshot bank and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      idx_r  <= '0;
      snap_r <= '{default: '0};
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        cnt_r <= CNT_W'(LATENCY);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (capture_s) begin
        idx_r  <= '0;
        snap_r <= live_s;
      end else if (advance_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Outputs decode only registered state, so out_ready never reaches out_valid.
  assign busy             = (state_r != IDLE);
  assign done             = done_r;
  assign out_if.out_valid = (state_r == STREAM);
  assign out_if.out_last  = (state_r == STREAM) && (idx_r == LAST_IDX);
  assign out_if.out_data  = (state_r == STREAM) ? requant(snap_r[idx_r]) : '0;

endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the small matrix multiplier. On a `start` pulse it waits a fixed compute latency, snapshots the multiplier's full N×N `resultMatrix`, requantizes each 2·WIDTH-bit element (arithmetic right shift, then saturate to OUT_WIDTH), and streams the elements out in row-major order over a valid/ready interface. It is the only path by which multiplier results leave the array toward the next layer or the host.

## Interface

- `WIDTH`, default 6: operand width of the multiplier. Input elements are 2·WIDTH bits, signed.
- `N`, default 3: matrix dimension. N·N elements are streamed per job.
- `OUT_WIDTH`, default 6: width of the streamed output element, signed. Legal range is 2 to 2·WIDTH.
- `SHIFT`, default 2: arithmetic right-shift amount applied before saturation. Legal range is 0 to 2·WIDTH-1.
- `LATENCY`, default 3·N: number of cycles from start acceptance to snapshot. Must be at least 1.
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): job request. Sampled only in IDLE.
- `resultMatrix` (in, signed [2·WIDTH-1:0] [N][N]): live result from the multiplier.
- `busy` (out, 1): high in WAIT and STREAM.
- `out_data` (out, signed OUT_WIDTH): requantized element.
- `out_valid` (out, 1): element available.
- `out_ready` (in, 1): consumer accepts the element.
- `out_last` (out, 1): marks element [N-1][N-1]. Only meaningful while `out_valid` is high.
- `done` (out, 1): one-cycle pulse after the last handshake.

## Operation

- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - When `start` is high at an edge, load `cnt` with LATENCY and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Decrement `cnt` every cycle.
  - On the edge where `cnt`==1: capture all N·N `resultMatrix` elements into the snapshot bank, clear `idx` to 0, and go to STREAM.
  - `start` is ignored.
- STREAM:
  - `out_valid` is high.
  - `out_data` = sat(snap[idx/N][idx%N] >>> SHIFT).
  - On handshake (`out_valid`&&`out_ready`):
    - If `idx` < N·N-1, increment `idx`.
    - If `idx` == N·N-1, go to IDLE and assert `done` for the following cycle.
  - Without `out_ready`, `out_data`, `out_last` and `idx` hold stable. There is no timeout.
  - `start` is ignored.
- Requantization:
  - Arithmetic shift, rounding toward −∞ (truncation of the shifted-out bits).
  - sat clamps to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - When OUT_WIDTH = 2·WIDTH and SHIFT = 0, the output is the identity.
- `out_last` = (STREAM && `idx` == N·N−1).
- The snapshot bank isolates the output stream from `resultMatrix`: changes on `resultMatrix` after capture do not affect the stream.
- Reset (asynchronous, at any time, including mid-WAIT or mid-STREAM):
  - FSM goes to IDLE.
  - `cnt`, `idx` and the snapshot bank are zeroed.
  - All outputs go to 0: `busy`, `out_valid`, `out_last`, `done`, `out_data`.
  - An in-flight job is discarded without a `done` pulse.

## Timing

- Start accepted at edge E0. Snapshot taken at edge E0+LATENCY. `out_valid` is first high in the cycle after that edge.
- With a consumer that holds `out_ready` continuously high:
  - Elements transfer one per cycle.
  - The last handshake occurs at edge E0+LATENCY+N·N.
  - `done` is high in the following cycle.
- `busy` rises in the cycle after E0 and falls in the cycle `done` is high.
- Back-to-back jobs: `start` high during the `done` cycle is accepted, giving no idle gap beyond that cycle.
- `out_data` and `out_last` are registered, or combinational from registered `snap`/`idx` only. There is no combinational path from `out_ready` to `out_valid`.

## Test plan

- Reset values: assert `rst_n`=0 with random inputs -> all outputs 0 and FSM in IDLE. Release reset with no `start` for 20 cycles -> outputs stay 0.
- Latency and order (N=3, LATENCY=9, SHIFT=0, OUT_WIDTH=12): `resultMatrix`[r][c]=10·r+c, `start` at E0, `out_ready`=1 -> valid from cycle E0+10. Sequence is 0,1,2,10,11,12,20,21,22. `out_last` is only on 22. `done` is one cycle after that element.
- Requantization (SHIFT=2, OUT_WIDTH=6): elements 100, 200, −200, −5, 0, 127, −128, 3, −1 -> outputs 25, 31, −32, −2, 0, 31, −32, 0, −1.
- Backpressure and snapshot isolation:
  - Toggle `out_ready` pseudo-randomly -> `out_data` is stable while stalled, and there are exactly 9 handshakes in order.
  - Change `resultMatrix` to all 0x7FF after the snapshot -> the streamed values are unchanged.
- Ignored start: pulse `start` during WAIT and during STREAM -> no restart, and exactly one `done`. A `start` in the `done` cycle launches a second job with correct timing.
- Reset mid-operation: drop `rst_n` during STREAM after 4 handshakes -> outputs are 0 immediately (asynchronous), no `done` is pulsed, and a subsequent job streams all 9 elements from index 0.
